// File: rtl/fir_polyphase_param.sv
// Parameterised polyphase FIR filter with runtime-writable coefficients and a two-stage pipeline.
// Optional output saturation is enabled by defining FIR_OUT_SAT_EN; otherwise the output wraps.
module fir_polyphase_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 321,
  parameter int L      = 3,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 32,
  localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  data_out,
  output logic              out_sat
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  logic signed [DATA_W-1:0] hist_q   [TAPS];
  logic signed [COEF_W-1:0] coef_q   [TAPS];
  logic signed [DATA_W-1:0] window   [TAPS];
  logic signed [ACC_W-1:0]  branch_d [L];
  logic signed [ACC_W-1:0]  branch_q [L];
  logic                     valid1_q;
  logic                     outValid_q;
  logic                     outSat_q;
  logic [OUT_W-1:0]         dataOut_q;
  logic signed [ACC_W-1:0]  accSum;
  logic signed [EXT_W-1:0]  shifted;
  logic [OUT_W-1:0]         result_d;
  logic                     sat_d;

  // The window the incoming sample will see once history has shifted.
  always_comb begin
    window[0] = data_in;
    for (int i = 1; i < TAPS; i++) begin
      window[i] = hist_q[i-1];
    end
  end

  // Branch p owns taps p, p+L, p+2L, ...
  always_comb begin
    for (int p = 0; p < L; p++) begin
      branch_d[p] = '0;
      for (int i = p; i < TAPS; i += L) begin
        branch_d[p] = branch_d[p] + ACC_W'(window[i]) * ACC_W'(coef_q[i]);
      end
    end
  end

  always_comb begin
    accSum = '0;
    for (int p = 0; p < L; p++) begin
      accSum = accSum + branch_q[p];
    end
    shifted = EXT_W'(accSum) >>> SHIFT;
  end

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX = (EXT_W'(1) << (OUT_W-1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = -(EXT_W'(1) << (OUT_W-1));

  always_comb begin
    result_d = shifted[OUT_W-1:0];
    sat_d    = 1'b0;
    if (shifted > OUT_MAX) begin
      result_d = OUT_MAX[OUT_W-1:0];
      sat_d    = 1'b1;
    end else if (shifted < OUT_MIN) begin
      result_d = OUT_MIN[OUT_W-1:0];
      sat_d    = 1'b1;
    end
  end
`else
  logic unusedShiftBits;

  assign result_d        = shifted[OUT_W-1:0];
  assign sat_d           = 1'b0;
  assign unusedShiftBits = ^shifted;
`endif

  // Clear flushes history and pipeline but keeps coefficients and the last output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      for (int p = 0; p < L; p++) begin
        branch_q[p] <= '0;
      end
      valid1_q   <= 1'b0;
      outValid_q <= 1'b0;
      outSat_q   <= 1'b0;
      dataOut_q  <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_we && (coef_addr == ADDR_W'(i))) begin
          coef_q[i] <= coef_data;
        end
      end
      if (clear) begin
        for (int i = 0; i < TAPS; i++) begin
          hist_q[i] <= '0;
        end
        for (int p = 0; p < L; p++) begin
          branch_q[p] <= '0;
        end
        valid1_q   <= 1'b0;
        outValid_q <= 1'b0;
      end else begin
        if (in_valid) begin
          for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= window[i];
          end
        end
        for (int p = 0; p < L; p++) begin
          branch_q[p] <= branch_d[p];
        end
        valid1_q   <= in_valid;
        outValid_q <= valid1_q;
        if (valid1_q) begin
          dataOut_q <= result_d;
          outSat_q  <= sat_d;
        end
      end
    end
  end

  assign out_valid = outValid_q;
  assign data_out  = dataOut_q;
  assign out_sat   = outSat_q;

endmodule
